operand_bus_arbiter: RTL and testbench

- Shares the single 192-bit operand bus into the vector ALU between two requesters: the scalar unit and the vector register file.
- The scalar unit supplies a 32-bit operand, which is broadcast across all lanes. The vector register file supplies a 192-bit operand (6 lanes x 32 bits).
- The block arbitrates with a burst-limited round robin, registers the selected operand, and drives the select line of the downstream 2-to-1 operand mux.
- All traffic uses valid/ready handshakes.

---
 rtl/operand_bus_pkg.sv | 35 +++
 rtl/operand_bus_arbiter_rr.sv | 60 ++++++
 rtl/operand_bus_arbiter.sv | 111 +++++++++++
 tb/tb_operand_bus_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_bus_pkg.sv
// Shared definitions for the operand bus arbiter.
//   LANE_W / LANES / VEC_W : lane width, lane count and full operand width.
//   src_e                  : operand source encoding (also the downstream mux select).
//   state_e                : debug-visible transfer state.
//   expand_scalar()        : widens a scalar operand to the full bus width.
package operand_bus_pkg;

  localparam int unsigned LANE_W = 32;
  localparam int unsigned LANES  = 6;
  localparam int unsigned VEC_W  = LANES * LANE_W;

  typedef enum logic {
    SRC_SCALAR = 1'b0,
    SRC_VECTOR = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    STALL = 2'd2
  } state_e;

  // bcast=1 replicates the scalar into every lane; bcast=0 zero-extends it into lane 0.
  function automatic logic [VEC_W-1:0] expand_scalar(input logic [LANE_W-1:0] data,
                                                     input logic              bcast);
    logic [VEC_W-1:0] res;
    if (bcast) begin
      res = {LANES{data}};
    end else begin
      res = {{(VEC_W - LANE_W){1'b0}}, data};
    end
    return res;
  endfunction

endpackage

// File: rtl/operand_bus_arbiter_rr.sv
// Two-source burst-limited round-robin arbiter (module rr_arbiter2).
//   clk, rst_n : clock, asynchronous active-low reset.
//   s_valid    : scalar source requesting.
//   v_valid    : vector source requesting.
//   advance    : a grant is taken this cycle; updates last_src / burst_cnt.
//   has_win    : at least one source is requesting.
//   win        : selected source (meaningful only when has_win is high).
module rr_arbiter2
  import operand_bus_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_valid,
  input  logic v_valid,
  input  logic advance,
  output logic has_win,
  output src_e win
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  src_e       last_src_q;
  logic [3:0] burst_cnt_q;

  assign has_win = s_valid | v_valid;

  always_comb begin
    win = SRC_SCALAR;
    if (s_valid && v_valid) begin
      // Keep the current source until its burst budget is spent, then hand over.
      if (burst_cnt_q < MaxBurst) begin
        win = last_src_q;
      end else begin
        win = (last_src_q == SRC_SCALAR) ? SRC_VECTOR : SRC_SCALAR;
      end
    end else if (v_valid) begin
      win = SRC_VECTOR;
    end
  end

  // Uncontended grants also count, so a long solo stream yields at once on contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_src_q  <= SRC_SCALAR;
      burst_cnt_q <= 4'd0;
    end else if (advance && has_win) begin
      if (win == last_src_q) begin
        if (burst_cnt_q < MaxBurst) begin
          burst_cnt_q <= burst_cnt_q + 4'd1;
        end
      end else begin
        burst_cnt_q <= 4'd1;
        last_src_q  <= win;
      end
    end
  end

endmodule

// File: rtl/operand_bus_arbiter.sv
// Operand bus arbiter: shares the vector-ALU operand bus between the scalar unit and the
// vector register file, registers the selected operand and drives the operand-mux select.
//   clk, rst_n          : clock, asynchronous active-low reset.
//   s_valid/s_data      : scalar operand request; s_ready accepts it.
//   v_valid/v_data      : vector operand request; v_ready accepts it.
//   out_valid/out_data  : registered operand; out_ready consumes it.
//   out_src, sel        : source of out_data (0 scalar, 1 vector); sel drives the mux.
module operand_bus_arbiter #(
  parameter int unsigned LANES     = 6,
  parameter int unsigned LANE_W    = 32,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned BCAST     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  input  logic [LANE_W-1:0]       s_data,
  output logic                    s_ready,
  input  logic                    v_valid,
  input  logic [LANES*LANE_W-1:0] v_data,
  output logic                    v_ready,
  output logic                    out_valid,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    out_src,
  input  logic                    out_ready,
  output logic                    sel
);

  import operand_bus_pkg::*;

  logic                    load;
  logic                    xfer;
  logic                    has_win;
  src_e                    win;
  logic                    out_valid_q;
  logic [LANES*LANE_W-1:0] out_data_q;
  logic                    out_src_q;
  logic                    sel_q;
  state_e                  state_q, state_d;

  rr_arbiter2 #(
    .MAX_BURST(MAX_BURST)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .v_valid(v_valid),
    .advance(xfer),
    .has_win(has_win),
    .win    (win)
  );

  // The output register can take a new operand when empty or being drained.
  assign load = ~out_valid_q | out_ready;
  assign xfer = load & has_win;

  // Readies are gated by rst_n so nothing is accepted while reset is asserted.
  assign s_ready = rst_n & load & has_win & (win == SRC_SCALAR) & s_valid;
  assign v_ready = rst_n & load & has_win & (win == SRC_VECTOR) & v_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      sel_q       <= 1'b0;
    end else if (load) begin
      if (has_win) begin
        out_valid_q <= 1'b1;
        out_src_q   <= win;
        sel_q       <= win;
        out_data_q  <= (win == SRC_VECTOR) ? v_data : expand_scalar(s_data, BCAST != 0);
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) state_d = XFER;
      end
      XFER, STALL: begin
        if (!out_ready) begin
          state_d = STALL;
        end else if (xfer) begin
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_operand_bus_arbiter.sv
module tb_operand_bus_arbiter;
  import operand_bus_pkg::*;

  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid, v_valid, out_ready;
  logic [31:0]  s_data;
  logic [191:0] v_data;
  logic         s_ready, v_ready, out_valid, out_src, sel;
  logic [191:0] out_data;
  logic         s_ready0, v_ready0, out_valid0, out_src0, sel0;
  logic [191:0] out_data0;

  always #5 clk = ~clk;

  operand_bus_arbiter #(.LANES(6), .LANE_W(32), .MAX_BURST(MB), .BCAST(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .v_valid(v_valid), .v_data(v_data), .v_ready(v_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .sel(sel)
  );

  // Zero-extend variant sharing the same inputs.
  operand_bus_arbiter #(.LANES(6), .LANE_W(32), .MAX_BURST(MB), .BCAST(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready0),
    .v_valid(v_valid), .v_data(v_data), .v_ready(v_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_src(out_src0),
    .out_ready(out_ready), .sel(sel0)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus and how many grants in a row it has had.
  int           m_last, m_cnt;
  bit           m_ov, m_src;
  logic [191:0] m_data, m_data0;
  state_e       m_state;
  bit           smp_sr, smp_vr;

  typedef struct {
    logic         sv;
    logic [31:0]  sd;
    logic         vv;
    logic [191:0] vd;
    logic         ordy;
    logic         e_sr, e_vr, e_ov, e_src;
    logic [191:0] e_data, e_data0;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_last = 0; m_cnt = 0; m_ov = 0; m_src = 0;
    m_data = '0; m_data0 = '0; m_state = IDLE;
  endtask

  task automatic do_reset();
    s_valid = 1'b1; v_valid = 1'b1; out_ready = 1'b1;
    s_data = 32'h0; v_data = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_v_ready", v_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_out_data", out_data, 0);
    s_valid = 1'b0; v_valid = 1'b0;
    rst_n = 1'b1;
    m_reset();
  endtask

  // One clock: drive, check readies at negedge, check registered outputs after posedge.
  task automatic cycle(input logic sv, input logic [31:0] sd, input logic vv,
                       input logic [191:0] vd, input logic ordy);
    int win;
    bit load;
    s_valid = sv; s_data = sd; v_valid = vv; v_data = vd; out_ready = ordy;
    load = !m_ov || ordy;
    if (sv && vv)  win = (m_cnt < MB) ? m_last : 1 - m_last;
    else if (sv)   win = 0;
    else if (vv)   win = 1;
    else           win = -1;
    @(negedge clk);
    smp_sr = s_ready; smp_vr = v_ready;
    chk("s_ready", s_ready, load && win == 0);
    chk("v_ready", v_ready, load && win == 1);
    @(posedge clk);
    if (load) begin
      if (win >= 0) begin
        m_ov = 1; m_src = win[0];
        m_data  = (win == 1) ? vd : {6{sd}};
        m_data0 = (win == 1) ? vd : {160'b0, sd};
        if (win == m_last) m_cnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
        else begin m_cnt = 1; m_last = win; end
      end else begin
        m_ov = 0;
      end
    end
    m_state = !m_ov ? IDLE : (load ? XFER : STALL);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_src", out_src, m_src);
    chk("sel", sel, m_src);
    chk("out_data", out_data, m_data);
    chk("out_data_bcast0", out_data0, m_data0);
    chk("state", dut.state_q, m_state);
  endtask

  initial begin
    logic [191:0] vs, va, bs, zx, held;
    int exp_g[9];
    int g;
    vs = {6{32'h80000001}};
    va = {6{32'hAAAA5555}};
    bs = {6{32'hF0F0F0F0}};
    zx = {160'b0, 32'hF0F0F0F0};
    tbl[0] = '{1, 32'hF0F0F0F0, 0, '0, 1, 1, 0, 1, 0, bs, zx};
    tbl[1] = '{0, 32'h0,        1, vs, 1, 0, 1, 1, 1, vs, vs};
    tbl[2] = '{0, 32'h0,        0, '0, 1, 0, 0, 0, 1, vs, vs};
    tbl[3] = '{1, 32'h12345678, 1, va, 1, 0, 1, 1, 1, va, va};
    tbl[4] = '{1, 32'h12345678, 1, va, 0, 0, 0, 1, 1, va, va};

    rst_n = 1'b1;
    #1;
    do_reset();

    for (int i = 0; i < 5; i++) begin
      cycle(tbl[i].sv, tbl[i].sd, tbl[i].vv, tbl[i].vd, tbl[i].ordy);
      chk("tbl_s_ready", smp_sr, tbl[i].e_sr);
      chk("tbl_v_ready", smp_vr, tbl[i].e_vr);
      chk("tbl_out_valid", out_valid, tbl[i].e_ov);
      chk("tbl_sel", sel, tbl[i].e_src);
      chk("tbl_out_data", out_data, tbl[i].e_data);
      chk("tbl_out_data0", out_data0, tbl[i].e_data0);
    end

    // Contended burst from reset: S x4, V x4, S.
    do_reset();
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 9; i++) begin
      cycle(1, $urandom, 1, {6{$urandom}}, 1);
      g = smp_sr ? 0 : (smp_vr ? 1 : -1);
      chk("burst_grant", g, exp_g[i]);
      chk("burst_sel", sel, exp_g[i]);
    end

    // Stall with both sources valid, then resume.
    do_reset();
    cycle(1, 32'h11111111, 1, va, 1);
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h22222222, 1, va, 0);
      chk("stall_state", dut.state_q, STALL);
      chk("stall_data", out_data, held);
      chk("stall_ready", {smp_sr, smp_vr}, 0);
    end
    cycle(1, 32'h22222222, 1, va, 1);
    chk("resume_data", out_data, {6{32'h22222222}});

    // Vector streams alone, then scalar arrives and wins immediately.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 32'h0, 1, vs, 1);
    cycle(1, 32'h33333333, 1, vs, 1);
    chk("solo_yield", smp_sr, 1);
    chk("solo_yield_sel", sel, 0);

    // Asynchronous reset mid-stream.
    cycle(0, 32'h0, 1, vs, 1);
    chk("pre_rst_sel", sel, 1);
    s_valid = 1'b1; v_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_sel", sel, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_v_ready", v_ready, 0);
    #1 rst_n = 1'b1;
    m_reset();
    cycle(1, 32'h44444444, 1, vs, 1);
    chk("arst_first_grant", smp_sr, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
